// File: rtl/reg_port_pkg.sv
// Shared types and constants for the register-port arbiter.
package reg_port_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2,
        TURN    = 2'd3
    } arb_state_e;

    localparam int STORE_HOLD_MIN = 1;
    localparam int STORE_HOLD_MAX = 15;

    // Keeps an out-of-range hold length from producing a zero-length or oversized access.
    function automatic int clamp_hold(input int hold);
        if (hold < STORE_HOLD_MIN) return STORE_HOLD_MIN;
        if (hold > STORE_HOLD_MAX) return STORE_HOLD_MAX;
        return hold;
    endfunction

endpackage

// File: rtl/reg_port_arbiter.sv
// Round-robin arbiter giving bus IN (A) or IN2 (B) exclusive access to one register.
// Optional Store turnaround cycle: define REG_PORT_ARBITER_TURNAROUND_EN.
import reg_port_pkg::*;

module reg_port_arbiter #(
    parameter int STORE_HOLD = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic ReqA,
    input  logic ReqB,
    input  logic WrA,
    input  logic WrB,
    output logic GntA,
    output logic GntB,
    output logic DoneA,
    output logic DoneB,
    output logic Load,
    output logic Load2,
    output logic Store,
    output logic Store2,
    output logic Busy
);

    localparam int HOLD  = clamp_hold(STORE_HOLD);
    localparam int CNT_W = $clog2(HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD);

    arb_state_e       state_q, state_d;
    logic             wr_q;
    logic             rr_b_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic             grant_a, grant_b;
    logic             serving;
    logic             last_cyc;

    assign serving  = (state_q == SERVE_A) || (state_q == SERVE_B);
    assign last_cyc = wr_q || (hold_cnt_q == HOLD_LAST);

    always_comb begin
        state_d = state_q;
        grant_a = 1'b0;
        grant_b = 1'b0;
        case (state_q)
            IDLE: begin
                // rr_b_q set means A was served last, so B wins a tie.
                if (ReqA && (!ReqB || !rr_b_q)) begin
                    grant_a = 1'b1;
                    state_d = SERVE_A;
                end else if (ReqB) begin
                    grant_b = 1'b1;
                    state_d = SERVE_B;
                end
            end
            SERVE_A, SERVE_B: begin
                if (last_cyc) begin
`ifdef REG_PORT_ARBITER_TURNAROUND_EN
                    state_d = wr_q ? IDLE : TURN;
`else
                    state_d = IDLE;
`endif
                end
            end
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            wr_q       <= 1'b0;
            rr_b_q     <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant_a) begin
                wr_q   <= WrA;
                rr_b_q <= 1'b1;
            end else if (grant_b) begin
                wr_q   <= WrB;
                rr_b_q <= 1'b0;
            end
            // Counts access cycles 1..HOLD and saturates at HOLD.
            if (grant_a || grant_b) begin
                hold_cnt_q <= CNT_W'(1);
            end else if (serving && (hold_cnt_q != HOLD_LAST)) begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
            end else if (!serving) begin
                hold_cnt_q <= '0;
            end
        end
    end

    assign GntA   = (state_q == SERVE_A);
    assign GntB   = (state_q == SERVE_B);
    assign Load   = GntA && wr_q;
    assign Store  = GntA && !wr_q;
    assign Load2  = GntB && wr_q;
    assign Store2 = GntB && !wr_q;
    assign DoneA  = GntA && last_cyc;
    assign DoneB  = GntB && last_cyc;
    assign Busy   = (state_q != IDLE);

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Scoreboard bench for reg_port_arbiter: a transaction-level model predicts every access.
module tb_reg_port_arbiter;

    localparam int HOLD = 2;
`ifdef REG_PORT_ARBITER_TURNAROUND_EN
    localparam bit TURN_EN = 1'b1;
`else
    localparam bit TURN_EN = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic ReqA = 1'b0, ReqB = 1'b0, WrA = 1'b0, WrB = 1'b0;
    logic GntA, GntB, DoneA, DoneB, Load, Load2, Store, Store2, Busy;

    reg_port_arbiter #(.STORE_HOLD(HOLD)) dut (
        .Clk(Clk), .Reset(Reset), .ReqA(ReqA), .ReqB(ReqB), .WrA(WrA), .WrB(WrB),
        .GntA(GntA), .GntB(GntB), .DoneA(DoneA), .DoneB(DoneB),
        .Load(Load), .Load2(Load2), .Store(Store), .Store2(Store2), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit who;   // 0 = A, 1 = B
        bit wr;
        int start;
        int len;
        bit turn;
    } txn_t;

    txn_t exp_q[$];
    bit   gnt_log[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   n_gnt_obs = 0;
    int   n_done_obs = 0;

    // Reference model state: earliest cycle whose sampled request may be granted, and tie favour.
    int   next_free = 0;
    bit   favour_b = 1'b0;
    int   pushes = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Applies inputs for the current cycle and lets the model decide the next grant.
    task automatic set_inputs(input bit ra, input bit wa, input bit rb, input bit wb);
        txn_t t;
        ReqA = ra; WrA = wa; ReqB = rb; WrB = wb;
        if (cyc >= next_free && (ra || rb)) begin
            t.who   = (ra && rb) ? favour_b : rb;
            t.wr    = t.who ? wb : wa;
            t.start = cyc + 1;
            t.len   = t.wr ? 1 : HOLD;
            t.turn  = TURN_EN && !t.wr;
            favour_b  = !t.who;
            next_free = t.start + t.len + (t.turn ? 1 : 0);
            exp_q.push_back(t);
            pushes++;
        end
    endtask

    task automatic drive(input bit ra, input bit wa, input bit rb, input bit wb);
        @(posedge Clk);
        #2;
        set_inputs(ra, wa, rb, wb);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compares every cycle's outputs against the active expected transaction.
    initial begin : monitor
        txn_t act;
        bit   act_v = 1'b0;
        bit   in_acc = 1'b0;
        int   turn_cyc = -1;
        logic [8:0] obs, exp;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                exp_q.delete();
                act_v = 1'b0;
                in_acc = 1'b0;
                turn_cyc = -1;
            end else begin
                if (!act_v && exp_q.size() > 0 && exp_q[0].start == cyc) begin
                    act = exp_q.pop_front();
                    act_v = 1'b1;
                end
                exp = '0;
                if (act_v) begin
                    exp[8] = !act.who;
                    exp[7] = act.who;
                    exp[6] = !act.who && (cyc == act.start + act.len - 1);
                    exp[5] = act.who && (cyc == act.start + act.len - 1);
                    exp[4] = !act.who && act.wr;
                    exp[3] = act.who && act.wr;
                    exp[2] = !act.who && !act.wr;
                    exp[1] = act.who && !act.wr;
                    exp[0] = 1'b1;
                end else begin
                    exp[0] = (cyc == turn_cyc);
                end
                obs = {GntA, GntB, DoneA, DoneB, Load, Load2, Store, Store2, Busy};
                check(obs === exp, "outputs", int'(obs), int'(exp));
                check($countones({Load, Load2, Store, Store2}) <= 1 && !(GntA && GntB),
                      "exclusive", int'({GntA, GntB, Load, Load2, Store, Store2}), 0);
                if ((GntA || GntB) && !in_acc) begin
                    n_gnt_obs++;
                    in_acc = 1'b1;
                    gnt_log.push_back(GntB);
                end
                if (DoneA || DoneB) begin
                    n_done_obs++;
                    in_acc = 1'b0;
                end
                if (act_v && cyc == act.start + act.len - 1) begin
                    act_v = 1'b0;
                    if (act.turn) turn_cyc = cyc + 1;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int g0, d0;
        #1;
        check({GntA, GntB, DoneA, DoneB, Load, Load2, Store, Store2, Busy} == 9'd0,
              "reset_state", int'({GntA, GntB, Load, Load2, Store, Store2, Busy}), 0);
        @(posedge Clk);
        @(posedge Clk);
        #2;
        Reset = 1'b0;
        next_free = 0;
        favour_b = 1'b0;

        // Single Load on A, then single Store on B.
        set_inputs(1'b1, 1'b1, 1'b0, 1'b0);
        idle(4);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle(6);

        // Both requesting: round-robin order after B was served last.
        gnt_log.delete();
        pushes = 0;
        for (int i = 0; i < 40 && pushes < 4; i++) drive(1'b1, 1'b1, 1'b1, 1'b1);
        idle(4);
        check(gnt_log.size() >= 4, "rr_count", gnt_log.size(), 4);
        if (gnt_log.size() >= 4) begin
            check({gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]} == 4'b0101,
                  "rr_order", int'({gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]}), 5);
        end

        // Request withdrawn before the grant edge.
        @(posedge Clk);
        #2;
        ReqA = 1'b1;
        #2;
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Reset in the middle of a Store on A; next tie must go to A.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        Reset = 1'b1;
        #1;
        check(Store == 1'b0 && GntA == 1'b0 && Busy == 1'b0, "async_reset",
              int'({Store, GntA, Busy}), 0);
        @(posedge Clk);
        #2;
        Reset = 1'b0;
        next_free = 0;
        favour_b = 1'b0;
        gnt_log.delete();
        set_inputs(1'b1, 1'b1, 1'b1, 1'b1);
        idle(6);
        check(gnt_log.size() > 0 && gnt_log[0] == 1'b0, "rr_after_reset",
              gnt_log.size() > 0 ? int'(gnt_log[0]) : -1, 0);

        // Random traffic.
        g0 = n_gnt_obs;
        d0 = n_done_obs;
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle(20);
        check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
        check(n_done_obs - d0 == n_gnt_obs - g0, "done_per_grant",
              n_done_obs - d0, n_gnt_obs - g0);
        check(n_gnt_obs - g0 > 0, "random_grants", n_gnt_obs - g0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_port_arbiter.md
REG_PORT_ARBITER -- requirements
Module: reg_port_arbiter

Interface
REQ-001 SHALL have parameter STORE_HOLD, default 2, the number of cycles a Store/Store2 strobe stays high (legal range 1..15).
REQ-002 SHALL have port Clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports ReqA/ReqB, input, 1 each: access request from the requester on bus IN (A) or IN2 (B).
REQ-005 SHALL have ports WrA/WrB, input, 1 each: 1 = write bus into register (Load), 0 = register drives bus (Store).
REQ-006 SHALL have ports GntA/GntB, output, 1 each: the requester owns the register this cycle.
REQ-007 SHALL have ports DoneA/DoneB, output, 1 each: one-cycle pulse in the final cycle of the access.
REQ-008 SHALL have ports Load, Load2, Store, Store2, output, 1 each, driving the register's strobes of the same names.
REQ-009 SHALL have port Busy, output, 1: the state is not IDLE.

Function
REQ-010 SHALL implement a Moore FSM with states IDLE, SERVE_A, SERVE_B and TURN; all outputs are registered or decoded from state only.
REQ-011 SHALL, in IDLE with exactly one Req high, enter that requester's SERVE state on the next edge and latch its Wr.
REQ-012 SHALL, with ReqA and ReqB both high in IDLE, grant the requester not served last (round-robin); the pointer favours A after reset.
REQ-013 SHALL, in SERVE_A with latched Wr=1, hold GntA, Load and DoneA high for exactly 1 cycle.
REQ-014 SHALL, in SERVE_A with latched Wr=0, hold GntA and Store high for STORE_HOLD cycles, with DoneA high only in the last cycle; SERVE_B is identical using GntB, Load2, Store2 and DoneB.
REQ-015 SHALL assert at most one of Load, Load2, Store and Store2 in any cycle, and never assert GntA and GntB together.
REQ-016 SHALL complete an access once granted even if Req drops mid-access; Done still pulses.
REQ-017 SHALL treat a Req dropped before the grant edge as withdrawn, with no strobe issued.
REQ-018 SHALL treat Req still high in the cycle after Done as a new request, arbitrated under REQ-012.
REQ-019 SHALL ignore WrA/WrB changes after the grant edge.
REQ-020 SHALL count hold cycles with a counter of $clog2(STORE_HOLD+1) bits that saturates and never wraps.

Reset
REQ-021 SHALL, on Reset high, immediately force state IDLE, all outputs 0, the hold counter 0 and the round-robin pointer to A, including mid-access.
REQ-022 SHALL accept a Req at the first rising edge after Reset deasserts.

Configuration
REQ-023 SHALL, when REG_PORT_ARBITER_TURNAROUND_EN is defined, pass through TURN for one cycle (all strobes 0, Busy=1) after any Store/Store2 access before the next grant.
REQ-024 SHALL, without REG_PORT_ARBITER_TURNAROUND_EN, return from SERVE to IDLE directly; TURN is unreachable.

Structure
REQ-025 SHALL take the state enum type (IDLE/SERVE_A/SERVE_B/TURN) and the STORE_HOLD bound constants from shared package reg_port_pkg.
REQ-026 SHALL be a single module; the hold counter is inline and there is no sub-module.

Verification
REQ-027 SHALL cover: ReqA=1, WrA=1 at cycle 0 -> at cycle 1 Load=1, GntA=1, DoneA=1; all strobes 0 at cycle 2.
REQ-028 SHALL cover: ReqB=1, WrB=0, STORE_HOLD=2 -> Store2 high for cycles 1-2, DoneB only at cycle 2; with the macro, Busy=1 and strobes 0 at cycle 3.
REQ-029 SHALL cover: ReqA and ReqB high together, held for 4 accesses after reset -> grant order A, B, A, B.
REQ-030 SHALL cover: Reset pulsed in the middle of a Store access -> Store drops to 0 with no clock edge and Busy=0; the next simultaneous request goes to A.
REQ-031 SHALL cover: ReqA raised then dropped before the grant edge -> no GntA and no strobe.
REQ-032 SHALL cover: 200 cycles of random Req/Wr -> a checker sees no two strobes high in any cycle and exactly one Done per grant.
